// File: rtl/bank_stream_reader_pkg.sv
// Shared constants for the bank read-side master: bank muxcodes and FSM encoding.
package bank_stream_reader_pkg;

  localparam logic [1:0] MUX_IFACE = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_CTRL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/bank_stream_reader_skid2.sv
// Two-entry FIFO used as the capture skid between the bank read port and the stream output.
module stream_skid2 #(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_pop;

  // Push is never gated: the issuer only reads when a slot is guaranteed free.
  assign w_pop = i_pop & (r_count != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bank_stream_reader.sv
// Strided read master for one data bank: issues reads, captures the 1-cycle-latency
// word into a 2-entry skid and presents it as a valid/ready stream.
module bank_stream_reader
  import bank_stream_reader_pkg::*;
#(
  parameter int         W       = 64,
  parameter int         A       = 10,
  parameter logic [1:0] MUXCODE = MUX_DATA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [A-1:0] cmd_base,
  input  logic [A-1:0] cmd_stride,
  input  logic [A:0]   cmd_len,
  output logic         rd_en,
  output logic [A-1:0] rd_addr,
  output logic [1:0]   rd_muxcode,
  input  logic [W-1:0] rdd_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         done
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_cmd_ready;
  logic         r_done;
  logic         r_pend;
  logic         r_pend_last;
  logic [A-1:0] r_addr;
  logic [A-1:0] r_stride;
  logic [A:0]   r_len;
  logic [A:0]   r_issued;
  logic         w_accept;
  logic         w_issue;
  logic         w_final_issue;
  logic         w_pop;
  logic [1:0]   w_count;
  logic [W:0]   w_head;
  logic [2:0]   w_occ;

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_pop    = out_valid & out_ready;
  // A word popped this cycle frees its slot in time for a read issued now.
  assign w_occ    = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (cmd_len != '0)) w_next_state = ST_RUN;
        else                             w_next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (w_final_issue) w_next_state = ST_DRAIN;
        else               w_next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_pop && w_head[W]) w_next_state = ST_IDLE;
        else                    w_next_state = ST_DRAIN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: read issue and final-read detect.
  always_comb begin
    w_issue       = 1'b0;
    w_final_issue = 1'b0;
    if ((r_state == ST_RUN) && (r_issued != r_len) && (w_occ < 3'd2)) begin
      w_issue       = 1'b1;
      w_final_issue = (r_issued == (r_len - {{A{1'b0}}, 1'b1}));
    end else begin
      w_issue       = 1'b0;
      w_final_issue = 1'b0;
    end
  end

  // Command capture, address generation, in-flight tracking and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_issued    <= '0;
    end else begin
      r_cmd_ready <= (w_next_state == ST_IDLE);
      r_done      <= (w_accept & (cmd_len == '0)) | (w_pop & w_head[W]);
      r_pend      <= w_issue;
      r_pend_last <= w_final_issue;
      if (w_accept) begin
        r_addr   <= cmd_base;
        r_stride <= cmd_stride;
        r_len    <= cmd_len;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + {{A{1'b0}}, 1'b1};
      end
    end
  end

  stream_skid2 #(.DW(W + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pend),
    .i_data  ({r_pend_last, rdd_word}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign cmd_ready  = r_cmd_ready;
  assign rd_en      = w_issue;
  assign rd_addr    = r_addr;
  assign rd_muxcode = MUXCODE;
  assign out_valid  = (w_count != 2'd0);
  assign out_data   = w_head[W-1:0];
  assign out_last   = w_head[W];
  assign done       = r_done;

endmodule

// File: tb/tb_bank_stream_reader.sv
// Scoreboard bench for bank_stream_reader: a driver queues expected addresses and words,
// a negedge monitor checks reads, stream words, credit limit and done pulses.
module tb_bank_stream_reader;
  localparam int W = 64;
  localparam int A = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [A-1:0] cmd_base;
  logic [A-1:0] cmd_stride;
  logic [A:0]   cmd_len;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [1:0]   rd_muxcode;
  logic [W-1:0] rdd_word = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_hs_cyc = 0;
  int hs_start = 0;
  int outst = 0;
  int tog = 0;
  bit at_start = 1'b1;
  bit pend_done = 1'b0;
  bit rmode = 1'b0;
  logic         hs;
  logic [W:0]   exp_w;
  logic [A-1:0] addr_q[$];
  logic [W:0]   exp_q[$];

  always #5 clk = ~clk;

  bank_stream_reader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_muxcode(rd_muxcode), .rdd_word(rdd_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  function automatic logic [W-1:0] word_of(input logic [A-1:0] a);
    return {16'hC0DE, 6'd0, a, 32'h5A5A_0000 ^ {22'd0, ~a}};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Bank model with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rdd_word <= word_of(rd_addr);
  end

  // Downstream ready: always high, or the repeating pattern 1,0,0.
  always begin
    @(posedge clk);
    #1;
    out_ready = (rmode == 1'b0) || (tog == 0);
    tog = (tog == 2) ? 0 : tog + 1;
  end

  // Monitor: reads, credit limit, stream words and done timing.
  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
      pend_done = 1'b0;
      at_start = 1'b1;
    end else begin
      hs = out_valid & out_ready;
      check("done", {{W{1'b0}}, done}, {{W{1'b0}}, pend_done});
      pend_done = cmd_valid && cmd_ready && (cmd_len == '0);
      if (rd_en) begin
        check("credit", {{W{1'b0}}, (outst - int'(hs)) < 2}, {{W{1'b0}}, 1'b1});
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_addr: unexpected read at %0d", rd_addr);
        end else begin
          check("rd_addr", {{(W-A+1){1'b0}}, rd_addr}, {{(W-A+1){1'b0}}, addr_q.pop_front()});
        end
        outst++;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL word: unexpected word %h", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {out_last, out_data}, exp_w);
          if (at_start) hs_start = cyc;
          at_start = 1'b0;
          if (exp_w[W]) begin
            pend_done = 1'b1;
            last_hs_cyc = cyc;
            at_start = 1'b1;
          end
        end
        outst--;
      end
    end
  end

  task automatic send(input int base, input int stride, input int len);
    bit ok;
    logic [A-1:0] a;
    ok = 1'b0;
    cmd_base   = A'(base);
    cmd_stride = A'(stride);
    cmd_len    = (A+1)'(len);
    cmd_valid  = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept: got no cmd_ready expected accept");
    end else begin
      for (int i = 0; i < len; i++) begin
        a = A'(base + i * stride);
        addr_q.push_back(a);
        exp_q.push_back({(i == len - 1), word_of(a)});
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_base   = 10'h3AA;
    cmd_stride = 10'h155;
    cmd_len    = 11'd7;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain: got %0d words pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {{W{1'b0}}, cmd_ready}, '0);
    check("rst_rd_en", {{W{1'b0}}, rd_en}, '0);
    check("rst_rd_addr", {{(W-A+1){1'b0}}, rd_addr}, '0);
    check("rst_out", {out_last, out_data}, '0);
    check("rst_valid_done", {{(W-1){1'b0}}, out_valid, done}, '0);
    check("muxcode", {{(W-1){1'b0}}, rd_muxcode}, 65'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {{W{1'b0}}, cmd_ready}, 65'd1);

    // base 5, stride 1, len 4; first word two edges after the accept edge
    send(5, 1, 4);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("first_latency", 65'(cyc - acc_cyc), 65'd3);
    wait_idle();

    // wrap: 1020, 1023, 2
    send(1020, 3, 3);
    wait_idle();

    // back-pressure pattern 1,0,0
    rmode = 1'b1;
    send(100, 7, 4);
    wait_idle();
    rmode = 1'b0;

    // zero-length command
    send(9, 1, 0);
    wait_idle();

    // reset in the middle of a len=8 command
    send(200, 1, 8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    addr_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("abort_valid", {{W{1'b0}}, out_valid}, '0);
    check("abort_rd_en", {{W{1'b0}}, rd_en}, '0);
    check("abort_ready", {{W{1'b0}}, cmd_ready}, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_abort", {{W{1'b0}}, cmd_ready}, 65'd1);
    send(300, 2, 2);
    wait_idle();

    // full-bank back-to-back commands at one word per cycle
    send(0, 1, 1024);
    send(17, 1, 1024);
    check("b2b_accept", 65'(acc_cyc - last_hs_cyc), 65'd1);
    check("b2b_rate1", 65'(last_hs_cyc - hs_start), 65'd1023);
    wait_idle();
    check("b2b_rate2", 65'(last_hs_cyc - hs_start), 65'd1023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
